// File: rtl/fx_mul_pipe.sv
// Pipelined signed fixed-point multiplier with round-half-up and saturation, valid/ready on both sides.
// Optional macro FX_MUL_SAT_FLAG_EN adds sat_flag (per result) and sat_sticky outputs.
module fx_mul_pipe #(
    parameter int WIDTH   = 32,
    parameter int QINT    = 15,
    parameter int QFRAC   = 16,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result
`ifdef FX_MUL_SAT_FLAG_EN
    ,
    output logic             sat_flag,
    output logic             sat_sticky
`endif
);

    if (LATENCY < 3) begin : g_bad_latency
        $error("fx_mul_pipe: LATENCY must be at least 3");
    end
    if ((1 + QINT + QFRAC) != WIDTH || QFRAC < 1) begin : g_bad_qformat
        $error("fx_mul_pipe: Q format must satisfy 1+QINT+QFRAC == WIDTH with QFRAC >= 1");
    end

    localparam logic signed [2*WIDTH:0] RND_C   = {{(2*WIDTH){1'b0}}, 1'b1} << (QFRAC - 1);
    localparam logic signed [2*WIDTH:0] SAT_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH:0] SAT_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    // Product plus half an LSB, then arithmetic shift: rounds half-up toward +inf.
    function automatic logic signed [2*WIDTH:0] shift_rnd(input logic signed [2*WIDTH-1:0] p);
        logic signed [2*WIDTH:0] s;
        s = {p[2*WIDTH-1], p};
        s = s + RND_C;
        return s >>> QFRAC;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_val(input logic signed [2*WIDTH-1:0] p);
        logic signed [2*WIDTH:0] s;
        s = shift_rnd(p);
        if (s > SAT_MAX) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else if (s < SAT_MIN) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic clamps(input logic signed [2*WIDTH-1:0] p);
        logic signed [2*WIDTH:0] s;
        s = shift_rnd(p);
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    logic [LATENCY-1:0]        v_q, v_d;
    logic [LATENCY-1:0]        en;
    logic signed [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic signed [2*WIDTH-1:0] prod_q, prod_d;
    logic signed [WIDTH-1:0]   dly_q [2:LATENCY-1];
    logic signed [WIDTH-1:0]   dly_d [2:LATENCY-1];

    // A stage may load when it is empty or its successor is loading this edge.
    always_comb begin : flow_ctrl
        logic chain;
        chain = ready_in;
        en    = '0;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            chain = !v_q[i] || chain;
            en[i] = chain;
        end
        v_d    = v_q;
        v_d[0] = en[0] ? valid_in : v_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            if (en[i]) begin
                v_d[i] = v_q[i-1];
            end
        end
    end

    always_comb begin : datapath
        // stage 0: operand capture
        a_d = a_q;
        b_d = b_q;
        if (en[0] && valid_in) begin
            a_d = $signed(a);
            b_d = $signed(b);
        end
        // stage 1: full-width product
        prod_d = prod_q;
        if (en[1] && v_q[0]) begin
            prod_d = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        end
        // stage 2: round and saturate; stages 3.. are pure delay
        dly_d = dly_q;
        if (en[2] && v_q[1]) begin
            dly_d[2] = sat_val(prod_q);
        end
        for (int i = 3; i < LATENCY; i++) begin
            if (en[i] && v_q[i-1]) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            for (int i = 2; i < LATENCY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            for (int i = 2; i < LATENCY; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign ready_out = en[0];
    assign valid_out = v_q[LATENCY-1];
    assign result    = dly_q[LATENCY-1];

`ifdef FX_MUL_SAT_FLAG_EN
    logic sat_q [2:LATENCY-1];
    logic sat_d [2:LATENCY-1];
    logic sticky_q, sticky_d;

    // The clamp flag rides alongside the result through the delay stages.
    always_comb begin
        sat_d = sat_q;
        if (en[2] && v_q[1]) begin
            sat_d[2] = clamps(prod_q);
        end
        for (int i = 3; i < LATENCY; i++) begin
            if (en[i] && v_q[i-1]) begin
                sat_d[i] = sat_q[i-1];
            end
        end
        sticky_d = sticky_q || (valid_out && ready_in && sat_q[LATENCY-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            for (int i = 2; i < LATENCY; i++) begin
                sat_q[i] <= 1'b0;
            end
        end else begin
            sticky_q <= sticky_d;
            for (int i = 2; i < LATENCY; i++) begin
                sat_q[i] <= sat_d[i];
            end
        end
    end

    assign sat_flag   = sat_q[LATENCY-1];
    assign sat_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Self-checking bench for fx_mul_pipe: directed steps with a queue scoreboard of expected results.
module tb_fx_mul_pipe;
    localparam int W = 32;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready_out;
    logic         valid_out;
    logic [W-1:0] result;
`ifdef FX_MUL_SAT_FLAG_EN
    logic         sat_flag;
    logic         sat_sticky;
`endif

    fx_mul_pipe #(.WIDTH(W), .QINT(15), .QFRAC(16), .LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .result    (result)
`ifdef FX_MUL_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag),
        .sat_sticky(sat_sticky)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];
    int           cyc = 0;
    int           ret_cnt = 0;
    int           last_ret_cyc = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact 64-bit product, add half LSB, arithmetic shift, clamp.
    function automatic logic [W:0] exp_of(input logic [W-1:0] ia, input logic [W-1:0] ib);
        longint p, r;
        p = longint'($signed(ia)) * longint'($signed(ib));
        r = (p + 64'sd32768) >>> 16;
        if (r > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: retire on every edge that sees valid_out && ready_in; check hold while stalled.
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                assert (valid_out === 1'b1 && result === prev_res) else begin
                    errors++;
                    $error("FAIL stall_hold observed v=%b r=%h expected v=1 r=%h", valid_out, result, prev_res);
                end
            end
            if (valid_out && ready_in) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_result observed %h expected none", result);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (result === e[W-1:0]) else begin
                        errors++;
                        $error("FAIL result observed %h expected %h", result, e[W-1:0]);
                    end
`ifdef FX_MUL_SAT_FLAG_EN
                    checks++;
                    assert (sat_flag === e[W]) else begin
                        errors++;
                        $error("FAIL sat_flag observed %b expected %b", sat_flag, e[W]);
                    end
`endif
                end
                ret_cnt++;
                last_ret_cyc = cyc + 1;
            end
            prev_stall = valid_out && !ready_in;
            prev_res   = result;
        end
    end

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W:0] e,
                        input bit rnd_rdy, output int acc_cyc, output int waits);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        valid_in = 1'b1;
        a = ia;
        b = ib;
        while (!acc && n < 200) begin
            if (rnd_rdy) ready_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            if (!acc) n++;
        end
        checks++;
        assert (acc === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout observed %b expected 1", acc);
        end
        if (acc) exp_q.push_back(e);
        acc_cyc = cyc;
        waits = n;
    endtask

    task automatic drain(input bit rnd_rdy);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            ready_in = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", W'(exp_q.size()), '0);
    endtask

    initial begin
        int t, w, t0, wsum, r0, n;
        logic [W-1:0] ra, rb;

        ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", W'(valid_out), '0);
        chk("rst_result", result, '0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_out", W'(ready_out), 1);
`ifdef FX_MUL_SAT_FLAG_EN
        chk("rst_sticky", W'(sat_sticky), '0);
`endif

        // Basic product and exact latency
        ready_in = 1'b1;
        send(32'h0001_8000, 32'h0002_0000, {1'b0, 32'h0003_0000}, 1'b0, t, w);
        valid_in = 1'b0;
        chk("lat_early_0", W'(valid_out), '0);
        for (int i = 1; i < L - 1; i++) begin
            @(posedge clk);
            #1;
            chk("lat_early", W'(valid_out), '0);
        end
        @(posedge clk);
        #1;
        chk("lat_valid", W'(valid_out), 1);
        chk("lat_result", result, 32'h0003_0000);
        send(32'hFFFE_8000, 32'h0002_0000, {1'b0, 32'hFFFD_0000}, 1'b0, t, w);
        valid_in = 1'b0;
        drain(1'b0);

        // Rounding half-up
        send(32'h0000_0001, 32'h0000_8000, {1'b0, 32'h0000_0001}, 1'b0, t, w);
        send(32'hFFFF_FFFF, 32'h0000_8000, {1'b0, 32'h0000_0000}, 1'b0, t, w);
        valid_in = 1'b0;
        drain(1'b0);

        // Saturation
        send(32'h7FFF_0000, 32'h0002_0000, {1'b1, 32'h7FFF_FFFF}, 1'b0, t, w);
        send(32'h8000_0000, 32'h0002_0000, {1'b1, 32'h8000_0000}, 1'b0, t, w);
        valid_in = 1'b0;
        drain(1'b0);
`ifdef FX_MUL_SAT_FLAG_EN
        chk("sticky_set", W'(sat_sticky), 1);
`endif

        // Backpressure: fill exactly L stages, then stream the rest with random ready_in
        ready_in = 1'b0;
        for (int k = 1; k <= L; k++) begin
            send(W'(k) << 16, 32'h0001_0000, {1'b0, W'(k) << 16}, 1'b0, t, w);
            chk("fill_no_wait", W'(w), '0);
        end
        chk("fill_ready_low", W'(ready_out), '0);
        for (int k = L + 1; k <= 10; k++) begin
            send(W'(k) << 16, 32'h0001_0000, {1'b0, W'(k) << 16}, 1'b1, t, w);
        end
        valid_in = 1'b0;
        drain(1'b1);

        // Throughput: 100 back-to-back random pairs
        ready_in = 1'b1;
        r0 = ret_cnt;
        wsum = 0;
        t0 = 0;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 != 0) begin
                ra = W'($signed(ra) >>> 12);
                rb = W'($signed(rb) >>> 12);
            end
            send(ra, rb, exp_of(ra, rb), 1'b0, t, w);
            if (i == 0) t0 = t;
            wsum += w;
        end
        valid_in = 1'b0;
        chk("tp_no_stall", W'(wsum), '0);
        n = 0;
        while (ret_cnt < r0 + 100 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tp_count", W'(ret_cnt - r0), 100);
        chk("tp_last_cycle", W'(last_ret_cyc), W'(t0 + 99 + L));

        // Reset with results in flight
        ready_in = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            send(W'(k) << 16, 32'h0001_0000, {1'b0, W'(k) << 16}, 1'b0, t, w);
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", W'(valid_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", W'(valid_out), '0);
        chk("rst_async_result", result, '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", W'(ready_out), 1);
`ifdef FX_MUL_SAT_FLAG_EN
        chk("post_rst_sticky", W'(sat_sticky), '0);
`endif
        ready_in = 1'b1;
        send(32'h0003_0000, 32'h0003_0000, {1'b0, 32'h0009_0000}, 1'b0, t, w);
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("post_rst_valid", W'(valid_out), 1);
        chk("post_rst_result", result, 32'h0009_0000);
        drain(1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
